c3_fetch: RTL and testbench
===========================

Name: c3_fetch

Overview:
Instruction fetch front-end for the C3 core. Sits directly upstream of the instruction cache.
- Generates sequential word addresses and drives the cache request pair `ic_addr`/`ic_rq`.
- Captures `ic_data_out` when `ic_data_out_valid` is set.
- Buffers fetched words with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles PC redirects (branch/jump/exception) by flushing buffered words and restarting at the new PC.

Parameters:
- `RESET_PC`, default 32'h0: word address fetched first after reset.
- `FIFO_DEPTH_BITS`, default 2: log2 of the output FIFO depth (4 entries).
- `DRAIN_CYCLES`, default 3: cycles `ic_rq` stays low with `ic_addr` held after each access. Covers the cache's 2-stage request pipeline plus margin.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `ic_addr`  out  32  word address to the icache; held stable while `ic_rq` is high and during drain
- `ic_rq`  out  1  fetch request; held high until data returns
- `ic_data_out_valid`  in  1  cache data valid
- `ic_data_out`  in  32  cache data
- `redirect_valid`  in  1  one-cycle redirect pulse from execute
- `redirect_pc`  in  32  new fetch word address
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  decode accepts head entry
- `out_insn`  out  32  head instruction word
- `out_pc`  out  32  head instruction word address
- `busy`  out  1  high in S_WAIT or S_DRAIN

Behaviour:
- Reset (`reset`==0 at posedge), all registered:
  - `ic_rq`=0, `ic_addr`=`RESET_PC`, `pc`=`RESET_PC`.
  - FIFO count=0, so `out_valid`=0; `out_insn`=0, `out_pc`=0.
  - state=S_IDLE, `drain_cnt`=0.
  - Reset mid-fetch abandons the access; the cache's own reset handles its side.
- Addresses are word addresses; PC increments by 1 and wraps 32'hFFFFFFFF -> 0.
- Only one access outstanding at any time.
- FSM:
  - S_IDLE: if FIFO count < depth, set `ic_addr`<=`pc`, `ic_rq`<=1, go to S_WAIT. Otherwise stay.
  - S_WAIT: hold `ic_addr` and `ic_rq`=1. When `ic_data_out_valid`=1:
    - push {`pc`, `ic_data_out`};
    - `pc`<=`pc`+1; `ic_rq`<=0;
    - `drain_cnt`<=`DRAIN_CYCLES`-1; go to S_DRAIN.
    - There is no timeout; a miss simply waits in S_WAIT.
  - S_DRAIN: `ic_rq`=0, `ic_addr` held. `ic_data_out_valid` is ignored (trailing valids from the cache pipeline). Decrement `drain_cnt`; go to S_IDLE when it reaches 0.
- `ic_data_out_valid` outside S_WAIT is always discarded.
- Redirect (`redirect_valid`=1) has priority over everything in that cycle:
  - flush FIFO (count<=0), `pc`<=`redirect_pc`, `ic_rq`<=0;
  - from S_WAIT or S_DRAIN: go to S_DRAIN with `drain_cnt` reloaded;
  - from S_IDLE: stay in S_IDLE;
  - a coincident `ic_data_out_valid` is dropped;
  - a coincident pop is void, since the flush wins.
- FIFO rules:
  - Push and pop in the same cycle are legal at any count.
  - Issue only when count < depth; with a single outstanding access, a push can never overflow.
  - Pop when empty has no effect.
  - `out_insn`/`out_pc` are the head entry. When `out_valid`=0 they are don't-care, but they must not be X after reset.
- Latency:
  - Hit: `out_valid` rises no later than 6 cycles after `ic_rq` rises.
  - Steady hit throughput: one word per (3 + `DRAIN_CYCLES` + 1) cycles. This rate is accepted.

Decomposition:
- Package `c3_fetch_pkg`:
  - state encodings S_IDLE=0, S_WAIT=1, S_DRAIN=2 (2-bit);
  - entry width constant (64 = pc + insn);
  - `RESET_PC` default.
- Sub-module `c3_fetch_fifo`:
  - parameterised synchronous FIFO (width, depth bits);
  - ports: push, pop, flush, count, head data;
  - synchronous active-low reset.

Test Plan:
1. Reset with `RESET_PC`=0; cache model returns word=addr^32'hA5A50000 with 3-cycle hit latency; `out_ready`=1 -> `out_pc` sequence 0,1,2,3 with matching insn. Never more than one `ic_rq` rise per drain window; `ic_addr` never changes while `ic_rq`=1.
2. Miss model: valid arrives 40 cycles after request for addr 0x10 -> `ic_rq` held high for all 40 cycles at 0x10, exactly one push, `out_pc`=0x10.
3. `out_ready`=0 throughout -> exactly 4 entries (pcs 0-3), `out_valid`=1, no fifth `ic_rq` rise. Then `out_ready`=1 for one cycle -> entry pc 0 popped, fetch of pc 4 issues.
4. Redirect to 0x200 while in S_WAIT at pc 5, with valid in the same cycle -> word for 5 dropped, FIFO empty next cycle, `ic_rq` low for `DRAIN_CYCLES` cycles, next `ic_addr`=0x200.
5. Model emits extra valids for 2 cycles after `ic_rq` falls -> no duplicate FIFO entries.
6. Deassert `reset` mid-S_WAIT -> all outputs at reset values next cycle. PC wrap: redirect to 32'hFFFFFFFF -> `out_pc` FFFFFFFF then 0.

Source files
------------

// File: rtl/c3_fetch_pkg.sv
// Shared types and constants for the C3 instruction fetch front-end.
package c3_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam int          ENTRY_W      = 64;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Buffered entry layout: PC in the upper word, instruction in the lower word.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] pc,
                                                      input logic [31:0] insn);
        return {pc, insn};
    endfunction

endpackage

// File: rtl/c3_fetch_fifo.sv
// Small synchronous FIFO with flush; head entry is presented without a pop.
module c3_fetch_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DEPTH_BITS:0]   count,
    output logic [WIDTH-1:0]      head
);

    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] ZERO_CNT = {(DEPTH_BITS + 1){1'b0}};

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [DEPTH_BITS:0]   count_r;
    logic                  do_pop_s;
    logic                  do_push_s;

    // Qualify pop against empty and push against full (a same-cycle pop frees a slot).
    always_comb begin
        do_pop_s  = pop && (count_r != ZERO_CNT);
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_r <= {DEPTH_BITS{1'b0}};
            wr_ptr_r <= {DEPTH_BITS{1'b0}};
            count_r  <= ZERO_CNT;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            rd_ptr_r <= {DEPTH_BITS{1'b0}};
            wr_ptr_r <= {DEPTH_BITS{1'b0}};
            count_r  <= ZERO_CNT;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + DEPTH_BITS'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_BITS'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (DEPTH_BITS + 1)'(1);
                2'b01:   count_r <= count_r - (DEPTH_BITS + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/c3_fetch.sv
// C3 fetch front-end: one outstanding icache access, drain window after each
// access, small PC/instruction buffer towards decode, redirect flushes and restarts.
module c3_fetch
    import c3_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter int          FIFO_DEPTH_BITS = 2,
    parameter int          DRAIN_CYCLES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] ic_addr,
    output logic        ic_rq,
    input  logic        ic_data_out_valid,
    input  logic [31:0] ic_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    output logic        busy
);

    localparam int                       CNT_W        = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]         DRAIN_RELOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [FIFO_DEPTH_BITS:0] FIFO_FULL    = (FIFO_DEPTH_BITS + 1)'(1 << FIFO_DEPTH_BITS);

    fetch_state_t               state_r;
    logic [31:0]                pc_r;
    logic [31:0]                ic_addr_r;
    logic                       ic_rq_r;
    logic [CNT_W-1:0]           drain_cnt_r;
    logic                       push_s;
    logic                       pop_s;
    logic [FIFO_DEPTH_BITS:0]   fifo_count_s;
    logic [ENTRY_W-1:0]         fifo_head_s;

    // Only data returning for the live access is buffered; a redirect voids both push and pop.
    always_comb begin
        push_s = (state_r == S_WAIT) && ic_data_out_valid && !redirect_valid;
        pop_s  = out_ready && !redirect_valid;
    end

    c3_fetch_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (pack_entry(pc_r, ic_data_out)),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Fetch sequencer: issue, wait for data, then hold off while the cache pipeline empties.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            pc_r        <= RESET_PC;
            ic_addr_r   <= RESET_PC;
            ic_rq_r     <= 1'b0;
            drain_cnt_r <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            pc_r    <= redirect_pc;
            ic_rq_r <= 1'b0;
            if (state_r != S_IDLE) begin
                state_r     <= S_DRAIN;
                drain_cnt_r <= DRAIN_RELOAD;
            end else begin
                state_r <= S_IDLE;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (fifo_count_s < FIFO_FULL) begin
                        ic_addr_r <= pc_r;
                        ic_rq_r   <= 1'b1;
                        state_r   <= S_WAIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (ic_data_out_valid) begin
                        pc_r        <= pc_r + 32'd1;
                        ic_rq_r     <= 1'b0;
                        drain_cnt_r <= DRAIN_RELOAD;
                        state_r     <= S_DRAIN;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= S_IDLE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    ic_rq_r <= 1'b0;
                end
            endcase
        end
    end

    assign ic_addr   = ic_addr_r;
    assign ic_rq     = ic_rq_r;
    assign out_valid = (fifo_count_s != {(FIFO_DEPTH_BITS + 1){1'b0}});
    assign out_pc    = fifo_head_s[63:32];
    assign out_insn  = fifo_head_s[31:0];
    assign busy      = (state_r == S_WAIT) || (state_r == S_DRAIN);

endmodule

// File: tb/tb_c3_fetch.sv
// Directed bench for c3_fetch: an icache responder plus a transaction-level
// model of the delivered PC/instruction stream, checked every cycle.
module tb_c3_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DRAIN    = 3;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        reset;
    logic [31:0] ic_addr;
    logic        ic_rq;
    logic        ic_data_out_valid;
    logic [31:0] ic_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        busy;

    c3_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH_BITS(2), .DRAIN_CYCLES(DRAIN)) dut (
        .clk               (clk),
        .reset             (reset),
        .ic_addr           (ic_addr),
        .ic_rq             (ic_rq),
        .ic_data_out_valid (ic_data_out_valid),
        .ic_data_out       (ic_data_out),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_insn          (out_insn),
        .out_pc            (out_pc),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Reference model: expected buffer contents and next address to fetch.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] model_pc = RESET_PC;
    bit          chk_en = 0;
    bit          resp_real = 0;
    bit          m_prev_rq = 0;
    bit          had_high = 0;
    int          low_run = 0;
    logic [31:0] log_pc[$];
    logic [31:0] log_insn[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check(out_valid === (mq.size() != 0), "out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check(out_pc === mq[0].pc, "out_pc", out_pc, mq[0].pc);
                check(out_insn === mq[0].insn, "out_insn", out_insn, mq[0].insn);
            end
            if (ic_rq === 1'b1) begin
                check(ic_addr === model_pc, "ic_addr", ic_addr, model_pc);
                check(busy === 1'b1, "busy_rq", 32'(busy), 32'd1);
                if (!m_prev_rq) begin
                    check(mq.size() < DEPTH, "issue_room", 32'(mq.size()), 32'(DEPTH - 1));
                    if (had_high)
                        check(low_run >= DRAIN, "drain_gap", 32'(low_run), 32'(DRAIN));
                end
                had_high = 1;
                low_run  = 0;
            end else begin
                low_run++;
            end
            m_prev_rq = (ic_rq === 1'b1);
            // Advance the model by what the coming clock edge must do.
            if (reset === 1'b0) begin
                mq.delete();
                model_pc = RESET_PC;
                had_high = 0;
                low_run  = 0;
            end else if (redirect_valid) begin
                mq.delete();
                model_pc = redirect_pc;
            end else begin
                if (out_ready && mq.size() != 0) begin
                    log_pc.push_back(out_pc);
                    log_insn.push_back(out_insn);
                    void'(mq.pop_front());
                end
                if (resp_real && ic_data_out_valid) begin
                    mq.push_back('{pc: model_pc, insn: word_of(model_pc)});
                    model_pc = model_pc + 32'd1;
                end
            end
        end
    end

    // Cache responder and redirect source; the only driver of DUT inputs besides main.
    int          lat = 3;
    int          extra_cfg = 0;
    int          wait_cnt = 0;
    int          extra_left = 0;
    bit          responded = 0;
    bit          redir_now = 0;
    logic [31:0] redir_now_pc = 32'h0;
    bit          redir_on_resp = 0;
    logic [31:0] redir_trig_addr = 32'h0;
    logic [31:0] redir_on_resp_pc = 32'h0;
    int          rises = 0;
    bit          prev_rq_m = 0;
    bit          prev_ov = 0;
    bit          lat_chk = 0;
    int          cyc = 0;
    int          rise_cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ic_rq && !prev_rq_m) begin
            rises++;
            rise_cyc = cyc;
        end
        if (lat_chk && out_valid && !prev_ov)
            check((cyc - rise_cyc) <= 6, "hit_latency", 32'(cyc - rise_cyc), 32'd6);
        prev_rq_m = ic_rq;
        prev_ov   = out_valid;
        redirect_valid    = 1'b0;
        resp_real         = 1'b0;
        ic_data_out_valid = 1'b0;
        ic_data_out       = 32'hDEAD_BEEF;
        if (!ic_rq) begin
            wait_cnt  = 0;
            responded = 0;
        end
        if (extra_left > 0) begin
            ic_data_out_valid = 1'b1;
            ic_data_out       = 32'hD00D_0000 + 32'(extra_left);
            extra_left--;
        end else if (ic_rq && !responded) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                ic_data_out_valid = 1'b1;
                ic_data_out       = word_of(ic_addr);
                resp_real         = 1'b1;
                responded         = 1;
                extra_left        = extra_cfg;
                if (redir_on_resp && ic_addr == redir_trig_addr) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = redir_on_resp_pc;
                    redir_on_resp  = 0;
                end
            end
        end
        if (redir_now) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_now_pc;
            redir_now      = 0;
        end
    endtask

    task automatic run_until_pops(input int n, input int budget, input string name);
        int k = 0;
        while (log_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        check(log_pc.size() >= n, name, 32'(log_pc.size()), 32'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(ic_rq === 1'b0, {tag, "_ic_rq"}, 32'(ic_rq), 32'd0);
        check(ic_addr === RESET_PC, {tag, "_ic_addr"}, ic_addr, RESET_PC);
        check(out_valid === 1'b0, {tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check(out_pc === 32'h0, {tag, "_out_pc"}, out_pc, 32'h0);
        check(out_insn === 32'h0, {tag, "_out_insn"}, out_insn, 32'h0);
        check(busy === 1'b0, {tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int r0;
        int rq_high;
        int k;
        int low;
        reset             = 1'b0;
        out_ready         = 1'b1;
        ic_data_out_valid = 1'b0;
        ic_data_out       = 32'h0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        repeat (2) step();
        chk_en = 1;
        step();
        check_reset_outputs("reset");

        // 1: sequential hits from RESET_PC.
        lat_chk = 1;
        reset   = 1'b1;
        run_until_pops(4, 100, "t1_pops");
        lat_chk = 0;
        for (int i = 0; i < 4; i++) begin
            check(log_pc[i] === 32'(i), "t1_pc", log_pc[i], 32'(i));
        end
        check(log_insn[0] === 32'hA5A5_0000, "t1_insn0", log_insn[0], 32'hA5A5_0000);
        check(log_insn[3] === 32'hA5A5_0003, "t1_insn3", log_insn[3], 32'hA5A5_0003);

        // 2: 40-cycle miss at 0x10.
        lat = 40;
        redir_now = 1;
        redir_now_pc = 32'h10;
        step();
        log_pc.delete();
        log_insn.delete();
        r0 = rises;
        rq_high = 0;
        k = 0;
        while (log_pc.size() < 1 && k < 200) begin
            step();
            k++;
            if (ic_rq) rq_high++;
        end
        check(log_pc.size() == 1, "t2_pops", 32'(log_pc.size()), 32'd1);
        check(rq_high == 40, "t2_rq_high", 32'(rq_high), 32'd40);
        check(rises - r0 == 1, "t2_rises", 32'(rises - r0), 32'd1);
        check(log_pc[0] === 32'h10, "t2_pc", log_pc[0], 32'h10);
        check(log_insn[0] === 32'hA5A5_0010, "t2_insn", log_insn[0], 32'hA5A5_0010);

        // 3: decode stalled, buffer fills to depth, then a single pop.
        lat = 3;
        out_ready = 1'b0;
        redir_now = 1;
        redir_now_pc = 32'h0;
        step();
        log_pc.delete();
        log_insn.delete();
        r0 = rises;
        repeat (80) step();
        check(rises - r0 == 4, "t3_rises", 32'(rises - r0), 32'd4);
        check(out_valid === 1'b1, "t3_out_valid", 32'(out_valid), 32'd1);
        check(out_pc === 32'h0, "t3_head_pc", out_pc, 32'h0);
        r0 = rises;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        k = 0;
        while (rises == r0 && k < 20) begin
            step();
            k++;
        end
        check(rises - r0 == 1, "t3_refetch", 32'(rises - r0), 32'd1);
        check(ic_addr === 32'h4, "t3_addr", ic_addr, 32'h4);
        check(log_pc.size() == 1, "t3_one_pop", 32'(log_pc.size()), 32'd1);

        // 4: redirect to 0x200 coinciding with the data for pc 5.
        out_ready = 1'b1;
        log_pc.delete();
        log_insn.delete();
        redir_on_resp = 1;
        redir_trig_addr = 32'h5;
        redir_on_resp_pc = 32'h200;
        k = 0;
        while (redir_on_resp && k < 100) begin
            step();
            k++;
        end
        check(!redir_on_resp, "t4_redirect_seen", 32'(redir_on_resp), 32'd0);
        step();
        check(out_valid === 1'b0, "t4_flushed", 32'(out_valid), 32'd0);
        low = 0;
        k = 0;
        while (!ic_rq && k < 20) begin
            low++;
            step();
            k++;
        end
        check(low >= DRAIN, "t4_low", 32'(low), 32'(DRAIN));
        check(ic_addr === 32'h200, "t4_addr", ic_addr, 32'h200);
        run_until_pops(5, 100, "t4_pops");
        check(log_pc[3] === 32'h4, "t4_before", log_pc[3], 32'h4);
        check(log_pc[4] === 32'h200, "t4_after", log_pc[4], 32'h200);

        // 5: trailing valids after each access.
        extra_cfg = 2;
        log_pc.delete();
        log_insn.delete();
        run_until_pops(4, 100, "t5_pops");
        for (int i = 0; i < 4; i++) begin
            check(log_pc[i] === 32'h201 + 32'(i), "t5_pc", log_pc[i], 32'h201 + 32'(i));
        end
        extra_cfg = 0;

        // 6: reset mid-access, then PC wrap.
        lat = 40;
        k = 0;
        while (!ic_rq && k < 30) begin
            step();
            k++;
        end
        check(ic_rq === 1'b1, "t6_in_wait", 32'(ic_rq), 32'd1);
        repeat (3) step();
        reset = 1'b0;
        step();
        check_reset_outputs("t6_reset");
        reset = 1'b1;
        lat = 3;
        redir_now = 1;
        redir_now_pc = 32'hFFFF_FFFF;
        log_pc.delete();
        log_insn.delete();
        run_until_pops(2, 100, "t6_pops");
        check(log_pc[0] === 32'hFFFF_FFFF, "t6_pc0", log_pc[0], 32'hFFFF_FFFF);
        check(log_pc[1] === 32'h0, "t6_pc1", log_pc[1], 32'h0);
        check(log_insn[0] === 32'h5A5A_FFFF, "t6_insn0", log_insn[0], 32'h5A5A_FFFF);
        check(log_insn[1] === 32'hA5A5_0000, "t6_insn1", log_insn[1], 32'hA5A5_0000);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
